// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one external combinational
// adder among N_REQ requesters. Operands are registered and drive the shared
// adder. The sum comes back tagged with the one-hot owner and a signed-overflow
// flag derived here, because the adder itself has no flag output.
module adder_share_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   reqA,
    input  logic [N_REQ*WIDTH-1:0]   reqB,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         addA,
    output logic [WIDTH-1:0]         addB,
    input  logic [WIDTH-1:0]         addSum,
    input  logic                     resStall,
    output logic                     resValid,
    output logic [WIDTH-1:0]         resSum,
    output logic                     resOvf,
    output logic [N_REQ-1:0]         resId
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [N_REQ-1:0] opId;
    logic             opValid;
    logic             res_full;
    logic             op_hold;
    logic             accept;

    // Result register is occupied and the consumer is not taking it.
    assign res_full = resStall && resValid;
    // Operand stage cannot advance into a stalled, occupied result stage.
    assign op_hold  = res_full && opValid;
    // Reset gates the grant so gnt reads 0 while rst_n is low.
    assign accept   = rst_n && (|req) && !op_hold;

    // The shared adder always sees the registered operands.
    assign addA = opA;
    assign addB = opB;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req[PTR_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        ptr_next = ptr;
        if (win_found) begin
            if (win_idx == PTR_W'(N_REQ - 1)) ptr_next = '0;
            else                              ptr_next = win_idx + PTR_W'(1);
        end
    end

    // One-hot grant pulse in the accept cycle.
    always_comb begin
        gnt = '0;
        if (accept) gnt[win_idx] = 1'b1;
    end

    // Operand stage and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            ptr     <= '0;
            opA     <= '0;
            opB     <= '0;
            opId    <= '0;
            opValid <= 1'b0;
        end else if (accept) begin
            opA     <= reqA[int'(win_idx)*WIDTH +: WIDTH];
            opB     <= reqB[int'(win_idx)*WIDTH +: WIDTH];
            opId    <= N_REQ'(1) << win_idx;
            opValid <= 1'b1;
            ptr     <= ptr_next;
        end else if (!op_hold) begin
            opValid <= 1'b0;
        end
    end

    // Result stage: capture the adder output, hold under stall, retire otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resSum   <= '0;
            resId    <= '0;
            resValid <= 1'b0;
            resOvf   <= 1'b0;
        end else if (opValid && !res_full) begin
            resSum   <= addSum;
            resId    <= opId;
            resValid <= 1'b1;
            resOvf   <= (opA[WIDTH-1] == opB[WIDTH-1]) && (addSum[WIDTH-1] != opA[WIDTH-1]);
        end else if (!res_full) begin
            resValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_adder_share_arbiter;

    localparam int N = 3;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   reqA;
    logic [N*W-1:0]   reqB;
    logic [N-1:0]     gnt;
    logic [W-1:0]     addA;
    logic [W-1:0]     addB;
    logic [W-1:0]     addSum;
    logic             resStall;
    logic             resValid;
    logic [W-1:0]     resSum;
    logic             resOvf;
    logic [N-1:0]     resId;

    always #5 clk = ~clk;

    // Stand-in for the shared combinational adder.
    assign addSum = addA + addB;

    adder_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .reqA     (reqA),
        .reqB     (reqB),
        .gnt      (gnt),
        .addA     (addA),
        .addB     (addB),
        .addSum   (addSum),
        .resStall (resStall),
        .resValid (resValid),
        .resSum   (resSum),
        .resOvf   (resOvf),
        .resId    (resId)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an accepted transaction and the result it produces.
    typedef struct { bit valid; int a; int b; int id; } op_t;
    typedef struct { bit valid; int sum; int id; bit ovf; } res_t;

    op_t  m_op;
    res_t m_res;
    int   m_ptr;
    int   a_in [N];
    int   b_in [N];

    function automatic int ref_sum(input int a, input int b);
        return (a + b) % 65536;
    endfunction

    function automatic bit ref_ovf(input int a, input int b);
        int sa, sb, s;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        s  = sa + sb;
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic int ref_winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_op      = '{0, 0, 0, 0};
        m_res     = '{0, 0, 0, 0};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req      = '0;
        resStall = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    // One clock cycle: drive at the falling edge, sample gnt 1 ns later,
    // advance the model across the rising edge, return at the next falling edge.
    task automatic step(input logic [N-1:0] r, input logic s,
                        output logic [N-1:0] got_g, output logic [N-1:0] exp_g);
        bit           acc, full;
        int           w;
        logic [N-1:0] one;
        one      = 1;
        req      = r;
        resStall = s;
        for (int i = 0; i < N; i++) begin
            reqA[i*W +: W] = W'(a_in[i]);
            reqB[i*W +: W] = W'(b_in[i]);
        end
        #1 got_g = gnt;
        full  = s && m_res.valid;
        acc   = (r != 0) && !(full && m_op.valid);
        w     = ref_winner(r);
        exp_g = acc ? (one << w) : '0;
        @(posedge clk);
        if (m_op.valid && !full)
            m_res = '{1, ref_sum(m_op.a, m_op.b), m_op.id, ref_ovf(m_op.a, m_op.b)};
        else if (!full)
            m_res.valid = 0;
        if (acc) begin
            m_op  = '{1, a_in[w], b_in[w], w};
            m_ptr = (w + 1) % N;
        end else if (!(m_op.valid && full)) begin
            m_op.valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            a_in[i] = $urandom_range(0, 65535);
            b_in[i] = $urandom_range(0, 65535);
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] one;
        one = 1;
        rst_n = 1'b0; req = 3'b101; resStall = 1'b0; reqA = '0; reqB = '0;
        #2;
        n_checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt got=%b exp=000", gnt); else n_pass++;
        n_checks++; if ({resValid, resOvf} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {resValid, resOvf}); else n_pass++;
        n_checks++; if ({resSum, resId} !== '0) $display("FAIL reset_result got=%h/%b exp=0/0", resSum, resId); else n_pass++;
        n_checks++; if ({addA, addB} !== '0) $display("FAIL reset_operands got=%h/%h exp=0/0", addA, addB); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if ({resValid, gnt} !== '0) $display("FAIL reset_held got=%b/%b exp=0/000", resValid, gnt); else n_pass++;
        apply_reset();
        // First request after reset starts at index 0.
        rand_ops();
        begin
            logic [N-1:0] g, e;
            step(3'b110, 1'b0, g, e);
            n_checks++; if (g !== 3'b010 || g !== e) $display("FAIL reset_first_gnt got=%b exp=010", g); else n_pass++;
        end
        step_idle(2);
    endtask

    task automatic step_idle(input int n);
        logic [N-1:0] g, e;
        for (int i = 0; i < n; i++) step('0, 1'b0, g, e);
    endtask

    task automatic test_single();
        logic [N-1:0] g, e;
        apply_reset();
        a_in[0] = 16'h0005; b_in[0] = 16'h0003;
        step(3'b001, 1'b0, g, e);
        n_checks++; if (g !== 3'b001) $display("FAIL single_gnt got=%b exp=001", g); else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b1) $display("FAIL single_valid got=%b exp=1", resValid); else n_pass++;
        n_checks++; if (resSum !== 16'h0008) $display("FAIL single_sum got=%h exp=0008", resSum); else n_pass++;
        n_checks++; if (resId !== 3'b001 || resOvf !== 1'b0) $display("FAIL single_id_ovf got=%b/%b exp=001/0", resId, resOvf); else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b0) $display("FAIL single_retire got=%b exp=0", resValid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, e;
        logic [N-1:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            rand_ops();
            step((c < 6) ? 3'b111 : 3'b000, 1'b0, g, e);
            if (c < 6) begin
                n_checks++; if (g !== seq[c] || g !== e) $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, g, seq[c]); else n_pass++;
            end
            if (c >= 1) begin
                n_checks++;
                if (resValid !== 1'b1 || resId !== seq[c-1] || int'(resSum) !== m_res.sum)
                    $display("FAIL rr_result[%0d] got=%b/%b/%h exp=1/%b/%h", c, resValid, resId, resSum, seq[c-1], m_res.sum);
                else n_pass++;
            end
        end
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b0) $display("FAIL rr_drain got=%b exp=0", resValid); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [N-1:0] g, e;
        apply_reset();
        a_in[0] = 16'h7FFF; b_in[0] = 16'h0001;
        step(3'b001, 1'b0, g, e);
        a_in[0] = 16'hFFFF; b_in[0] = 16'h0001;
        step(3'b001, 1'b0, g, e);
        n_checks++; if (g !== 3'b001) $display("FAIL ovf_gnt got=%b exp=001", g); else n_pass++;
        n_checks++; if (resSum !== 16'h8000 || resOvf !== 1'b1) $display("FAIL ovf_pos got=%h/%b exp=8000/1", resSum, resOvf); else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resSum !== 16'h0000 || resOvf !== 1'b0 || resValid !== 1'b1) $display("FAIL ovf_wrap got=%h/%b/%b exp=0000/0/1", resSum, resOvf, resValid); else n_pass++;
        step_idle(1);
    endtask

    task automatic test_stall();
        logic [N-1:0] g, e;
        int first_sum, second_sum;
        apply_reset();
        rand_ops();
        first_sum  = ref_sum(a_in[0], b_in[0]);
        second_sum = ref_sum(a_in[1], b_in[1]);
        step(3'b011, 1'b0, g, e);
        step(3'b011, 1'b0, g, e);
        n_checks++; if (g !== 3'b010) $display("FAIL stall_second_gnt got=%b exp=010", g); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step(3'b111, 1'b1, g, e);
            n_checks++; if (g !== 3'b000) $display("FAIL stall_gnt[%0d] got=%b exp=000", c, g); else n_pass++;
            n_checks++;
            if (resValid !== 1'b1 || resId !== 3'b001 || int'(resSum) !== first_sum)
                $display("FAIL stall_hold[%0d] got=%b/%b/%h exp=1/001/%h", c, resValid, resId, resSum, first_sum);
            else n_pass++;
        end
        step('0, 1'b0, g, e);
        n_checks++;
        if (resValid !== 1'b1 || resId !== 3'b010 || int'(resSum) !== second_sum)
            $display("FAIL stall_release got=%b/%b/%h exp=1/010/%h", resValid, resId, resSum, second_sum);
        else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b0) $display("FAIL stall_retire got=%b exp=0", resValid); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [N-1:0] g, e;
        apply_reset();
        rand_ops();
        step(3'b001, 1'b0, g, e);
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b1) $display("FAIL areset_pre got=%b exp=1", resValid); else n_pass++;
        req = 3'b111;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (resValid !== 1'b0 || gnt !== 3'b000) $display("FAIL areset_clear got=%b/%b exp=0/000", resValid, gnt); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (gnt !== 3'b001) $display("FAIL areset_ptr got=%b exp=001", gnt); else n_pass++;
        req = '0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_withdraw();
        logic [N-1:0] g, e;
        apply_reset();
        rand_ops();
        step(3'b011, 1'b0, g, e);
        n_checks++; if (g !== 3'b001) $display("FAIL wd_gnt got=%b exp=001", g); else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b1 || resId !== 3'b001) $display("FAIL wd_result got=%b/%b exp=1/001", resValid, resId); else n_pass++;
        step('0, 1'b0, g, e);
        n_checks++; if (resValid !== 1'b0) $display("FAIL wd_no_result got=%b exp=0", resValid); else n_pass++;
        step(3'b111, 1'b0, g, e);
        n_checks++; if (g !== 3'b010) $display("FAIL wd_ptr got=%b exp=010", g); else n_pass++;
        step_idle(2);
    endtask

    task automatic test_random();
        logic [N-1:0] g, e;
        logic [N-1:0] r;
        logic         s;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            rand_ops();
            if ($urandom_range(0, 3) == 0) begin
                a_in[0] = 16'h7FFF; b_in[1] = 16'h8000; a_in[2] = 16'hFFFF;
            end
            r = N'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0);
            step(r, s, g, e);
            n_checks++; if (g !== e) $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, g, e); else n_pass++;
            n_checks++;
            if (resValid !== m_res.valid)
                $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, resValid, m_res.valid);
            else if (m_res.valid && (int'(resSum) !== m_res.sum || resId !== (N'(1) << m_res.id) || resOvf !== m_res.ovf))
                $display("FAIL rnd_result[%0d] got=%h/%b/%b exp=%h/%0d/%b", c, resSum, resId, resOvf, m_res.sum, m_res.id, m_res.ovf);
            else n_pass++;
            if (m_op.valid) begin
                n_checks++;
                if (int'(addA) !== m_op.a || int'(addB) !== m_op.b)
                    $display("FAIL rnd_operands[%0d] got=%h/%h exp=%h/%h", c, addA, addB, m_op.a, m_op.b);
                else n_pass++;
            end
        end
        step_idle(3);
        n_checks++; if (resValid !== 1'b0) $display("FAIL rnd_drain got=%b exp=0", resValid); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_stall();
        test_async_reset();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
